// File: rtl/data_mem_mmio_pkg.sv
// Shared definitions for the data-side memory system: MMIO register map,
// STAT bit layout and the helpers used to decode and build MMIO words.
package dmem_pkg;

    // Byte offsets of the registers inside the 16-byte MMIO window
    localparam logic [3:0] OFF_TX     = 4'h0;
    localparam logic [3:0] OFF_STAT   = 4'h4;
    localparam logic [3:0] OFF_CYC_LO = 4'h8;
    localparam logic [3:0] OFF_CYC_HI = 4'hC;

    // STAT register bit positions
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    // Width of the FIFO occupancy field reported in STAT
    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        REG_TX     = 2'd0,
        REG_STAT   = 2'd1,
        REG_CYC_LO = 2'd2,
        REG_CYC_HI = 2'd3
    } mmio_reg_e;

    // Word accesses only: the low two offset bits are dropped before matching
    function automatic mmio_reg_e reg_decode(input logic [3:0] off);
        mmio_reg_e sel;
        sel = REG_TX;
        case ({off[3:2], 2'b00})
            OFF_TX:     sel = REG_TX;
            OFF_STAT:   sel = REG_STAT;
            OFF_CYC_LO: sel = REG_CYC_LO;
            OFF_CYC_HI: sel = REG_CYC_HI;
            default:    sel = REG_TX;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] stat_word(input logic [COUNT_W-1:0] count,
                                              input logic ovf,
                                              input logic empty,
                                              input logic full);
        logic [31:0] w;
        w = 32'h0;
        w[STAT_COUNT_LSB +: COUNT_W] = count;
        w[STAT_OVF]   = ovf;
        w[STAT_EMPTY] = empty;
        w[STAT_FULL]  = full;
        return w;
    endfunction

endpackage

// File: rtl/data_mem_mmio_console_fifo.sv
// Byte FIFO feeding the console sink. Overflowing pushes are dropped and
// latch a sticky ovf flag that software clears explicitly.
module console_fifo
    import dmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [7:0]         push_data,
    input  logic               pop,
    input  logic               ovf_clr,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count,
    output logic [7:0]         head,
    output logic               ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;
    logic             push_ok;
    logic             pop_ok;
    logic             overflow;

    assign full  = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt == '0);

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign push_ok  = push & (~full | pop);
    assign overflow = push & full & ~pop;
    assign pop_ok   = pop & ~empty;

    // Pointers, occupancy and sticky overflow; reset wins over any activity
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (overflow)     ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Byte storage; no reset needed since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_data;
    end

    assign head  = mem[rptr];
    assign count = COUNT_W'(cnt);
    assign ovf   = ovf_q;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory system for the single-cycle RV32 core: word RAM, MMIO
// console FIFO and a 64-bit cycle counter, with a combinational load path.
// Build option: define DMEM_CYCLE_COUNTER_EN to include the cycle counter
// and its high-word shadow; otherwise CYCLE_LO/CYCLE_HI read as zero.
module data_mem_mmio
    import dmem_pkg::*;
#(
    parameter int          RAM_DEPTH  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] mem_read_data,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [31:0]        ram [RAM_DEPTH];
    logic [29:0]        word_addr;
    logic [RAM_AW-1:0]  ram_idx;
    logic               ram_hit;
    logic               mmio_hit;
    mmio_reg_e          reg_sel;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_count;
    logic [7:0]         fifo_head;
    logic               fifo_ovf;
    logic               ovf_clr;

    assign word_addr = addr[31:2];
    assign ram_hit   = (addr[31:28] == 4'h0) && (word_addr < 30'(RAM_DEPTH));
    assign ram_idx   = addr[RAM_AW+1:2];
    assign mmio_hit  = (addr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel   = reg_decode(addr[3:0]);

    assign fifo_push = mem_write & mmio_hit & (reg_sel == REG_TX);
    assign ovf_clr   = mem_write & mmio_hit & (reg_sel == REG_STAT);
    assign fifo_pop  = con_valid & con_ready;

    console_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wdata[7:0]),
        .pop       (fifo_pop),
        .ovf_clr   (ovf_clr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head),
        .ovf       (fifo_ovf)
    );

    assign con_valid = ~fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_head;

    // Word RAM store; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_write && ram_hit) ram[ram_idx] <= wdata;
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [63:0] cyc;
    logic [31:0] hi_shadow;
    logic [31:0] cyc_lo_rd;
    logic [31:0] cyc_hi_rd;

    // Free-running cycle counter, zero in the first cycle after reset
    always_ff @(posedge clk) begin
        if (reset) cyc <= 64'h0;
        else       cyc <= cyc + 64'h1;
    end

    // Reading CYCLE_LO snapshots the upper word for a coherent 64-bit read
    always_ff @(posedge clk) begin
        if (reset)
            hi_shadow <= 32'h0;
        else if (mem_read && mmio_hit && (reg_sel == REG_CYC_LO))
            hi_shadow <= cyc[63:32];
    end

    assign cyc_lo_rd = cyc[31:0];
    assign cyc_hi_rd = hi_shadow;
`else
    logic [31:0] cyc_lo_rd;
    logic [31:0] cyc_hi_rd;

    assign cyc_lo_rd = 32'h0;
    assign cyc_hi_rd = 32'h0;
`endif

    // Combinational load mux; reads see state from before this cycle's store
    always_comb begin
        mem_read_data = 32'h0;
        if (mem_read) begin
            if (ram_hit) begin
                mem_read_data = ram[ram_idx];
            end else if (mmio_hit) begin
                case (reg_sel)
                    REG_TX:     mem_read_data = 32'h0;
                    REG_STAT:   mem_read_data = stat_word(fifo_count, fifo_ovf,
                                                          fifo_empty, fifo_full);
                    REG_CYC_LO: mem_read_data = cyc_lo_rd;
                    REG_CYC_HI: mem_read_data = cyc_hi_rd;
                    default:    mem_read_data = 32'h0;
                endcase
            end
        end
    end

endmodule
